// File: rtl/mod_counter_prog_if.sv
// Control and status bundle for one programmable modulo counter stage.
// The counter sits on the slave side; whoever drives the controls is the master.
interface mod_counter_prog_if #(
   parameter int WIDTH = 4
);
   logic             clear;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic             enable;
   logic             carry_in;
   logic             up_down;
   logic [WIDTH-1:0] final_value;
   logic [WIDTH-1:0] Q;
   logic             tc;
   logic             wrap_pulse;

   modport master (
      output clear, load, load_value, enable, carry_in, up_down, final_value,
      input  Q, tc, wrap_pulse
   );

   modport slave (
      input  clear, load, load_value, enable, carry_in, up_down, final_value,
      output Q, tc, wrap_pulse
   );
endinterface

// File: rtl/mod_counter_prog.sv
// Runtime-programmable modulo counter with up/down, load, clear, wrap or saturate,
// and a combinational carry chain (carry_in -> tc) for building wide timers.
module mod_counter_prog #(
   parameter int WIDTH    = 4,
   parameter bit SATURATE = 1'b0
) (
   input logic               clk,
   input logic               reset_n,
   mod_counter_prog_if.slave bus
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             wrap_q;
   logic             wrap_d;
   logic             step;
   logic             atTerm;
   logic [WIDTH-1:0] decVal;

   // The terminal test depends on direction: top of range going up, zero going down.
   // Going up uses >= so a count loaded above final_value still counts as terminal.
   always_comb begin
      step   = bus.enable & bus.carry_in;
      atTerm = bus.up_down ? (count_q >= bus.final_value) : (count_q == '0);
      decVal = count_q - WIDTH'(1);
   end

   // Next count follows clear > load > step > hold; wrap_d marks a true wrap only.
   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      if (bus.clear) begin
         count_d = '0;
      end else if (bus.load) begin
         count_d = bus.load_value;
      end else if (step) begin
         if (bus.up_down) begin
            if (!atTerm) begin
               count_d = count_q + WIDTH'(1);
            end else if (SATURATE) begin
               count_d = bus.final_value;
            end else begin
               count_d = '0;
               wrap_d  = 1'b1;
            end
         end else begin
            if (!atTerm) begin
               count_d = (decVal > bus.final_value) ? bus.final_value : decVal;
            end else if (!SATURATE) begin
               count_d = bus.final_value;
               wrap_d  = 1'b1;
            end
         end
      end
   end

   // Count and wrap pulse registers; reset also kills a pulse that is in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
      end
   end

   assign bus.Q          = count_q;
   assign bus.wrap_pulse = wrap_q;
   assign bus.tc         = step & atTerm;

endmodule
